// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_ADDR_WIDTH  = 25;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_BE_WIDTH    = 2;
    localparam int DEF_Q_WIDTH     = 128;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_ACCEPT = 3'd2,
        ST_WAIT_DONE   = 3'd3,
        ST_DONE        = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requesting client at or after ptr.
module rr_picker #(
    parameter int NUM_CLIENTS = 4
) (
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic [$clog2(NUM_CLIENTS)-1:0] ptr,
    output logic                           valid,
    output logic [$clog2(NUM_CLIENTS)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    // Walk the clients from ptr with wrap-around and keep the first hit.
    always_comb begin
        int               sum;
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_CLIENTS) begin
                sum = sum - NUM_CLIENTS;
            end
            cand = IDX_W'(sum);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one sdram controller port among several clients.
// One transaction at a time: latch winner, pulse the request, follow the
// controller's ready low/high handshake, then strobe done to the winner.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BE_WIDTH    = DEF_BE_WIDTH,
    parameter int Q_WIDTH     = DEF_Q_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              init_complete,
    input  logic [NUM_CLIENTS-1:0]            cl_req,
    input  logic [NUM_CLIENTS-1:0]            cl_we,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_data,
    input  logic [NUM_CLIENTS*BE_WIDTH-1:0]   cl_byte_en,
    output logic [NUM_CLIENTS-1:0]            cl_done,
    output logic [Q_WIDTH-1:0]                cl_q,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_data,
    output logic [BE_WIDTH-1:0]               mem_byte_en,
    output logic                              mem_wr_req,
    output logic                              mem_rd_req,
    input  logic                              mem_ready,
    input  logic [Q_WIDTH-1:0]                mem_q,
    output logic                              busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    arb_state_t state;
    arb_state_t state_next;

    logic [IDX_W-1:0]      rr_ptr;
    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic                  start;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [BE_WIDTH-1:0]   lat_byte_en;

    rr_picker #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_picker (
        .req  (cl_req),
        .ptr  (rr_ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // A grant needs a calibrated, idle controller and at least one requester.
    assign start = init_complete && mem_ready && pick_valid;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and controller-facing outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        mem_wr_req  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_addr    = lat_addr;
        mem_data    = lat_data;
        mem_byte_en = lat_byte_en;
        cl_done     = '0;
        case (state)
            ST_IDLE: begin
                busy        = 1'b0;
                mem_addr    = '0;
                mem_data    = '0;
                mem_byte_en = '0;
                if (start) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_wr_req = lat_we;
                mem_rd_req = !lat_we;
                state_next = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (!mem_ready) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (mem_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cl_done[grant_id] = 1'b1;
                state_next        = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                mem_addr    = '0;
                mem_data    = '0;
                mem_byte_en = '0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    // Grant index, fairness pointer and returned read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            cl_q     <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                grant_id <= pick_idx;
            end
            if (state == ST_WAIT_DONE && mem_ready && !lat_we) begin
                cl_q <= mem_q;
            end
            if (state == ST_DONE) begin
                rr_ptr <= (grant_id == IDX_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Winner's command fields; only observed outside IDLE, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            lat_we      <= cl_we[pick_idx];
            lat_addr    <= cl_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            lat_data    <= cl_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            lat_byte_en <= cl_byte_en[pick_idx*BE_WIDTH +: BE_WIDTH];
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: behavioural controller port plus a queue of
// expected completions popped as cl_done strobes appear.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int BW = 2;
    localparam int QW = 128;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            init_complete;
    logic [N-1:0]    cl_req;
    logic [N-1:0]    cl_we;
    logic [N*AW-1:0] cl_addr;
    logic [N*DW-1:0] cl_data;
    logic [N*BW-1:0] cl_byte_en;
    logic [N-1:0]    cl_done;
    logic [QW-1:0]   cl_q;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data;
    logic [BW-1:0]   mem_byte_en;
    logic            mem_wr_req;
    logic            mem_rd_req;
    logic            mem_ready;
    logic [QW-1:0]   mem_q;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .Q_WIDTH(QW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_complete(init_complete),
        .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_data(cl_data),
        .cl_byte_en(cl_byte_en), .cl_done(cl_done), .cl_q(cl_q),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_byte_en(mem_byte_en),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_ready(mem_ready),
        .mem_q(mem_q), .busy(busy), .grant_id(grant_id)
    );

    // Read burst format of the controller model: tag, address, ~word, word.
    function automatic logic [QW-1:0] model_q(input logic [AW-1:0] a, input logic [DW-1:0] w);
        return {32'hDEAD_BEEF, 7'd0, a, ~w, w};
    endfunction

    // Controller model state (written only by the controller process).
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    int            proto_err = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [BW-1:0] last_be   = '0;
    // Knobs written only by the stimulus process.
    int            model_lat = 3;
    int            abort_gen = 0;

    initial begin : controller
        int            cnt;
        int            seen_abort;
        logic          op_we;
        logic [AW-1:0] op_addr;
        cnt        = 0;
        seen_abort = 0;
        op_we      = 1'b0;
        op_addr    = '0;
        mem_ready  = 1'b1;
        mem_q      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (abort_gen != seen_abort) begin
                seen_abort = abort_gen;
                cnt        = 0;
                mem_ready  = 1'b1;
            end else if (cnt > 0) begin
                if (mem_wr_req || mem_rd_req) proto_err++;
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    if (!op_we) mem_q = model_q(op_addr, mem.exists(op_addr) ? mem[op_addr] : '0);
                end
            end else if (mem_wr_req || mem_rd_req) begin
                if (mem_wr_req && mem_rd_req) proto_err++;
                op_we     = mem_wr_req;
                op_addr   = mem_addr;
                last_addr = mem_addr;
                last_data = mem_data;
                last_be   = mem_byte_en;
                if (mem_wr_req) begin
                    wr_pulses++;
                    mem[mem_addr] = mem_data;
                end else begin
                    rd_pulses++;
                end
                mem_ready = 1'b0;
                cnt       = model_lat;
            end
        end
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [QW-1:0] q;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [QW-1:0] cur_q = '0;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic set_client(input int c, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [BW-1:0] be);
        cl_we[c]              = we;
        cl_addr[c*AW +: AW]   = a;
        cl_data[c*DW +: DW]   = d;
        cl_byte_en[c*BW +: BW] = be;
        cl_req[c]             = 1'b1;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cl_done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cur_q   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        init_complete = 1'b0;
        cl_req        = '0;
        cl_we         = '0;
        cl_addr       = '0;
        cl_data       = '0;
        cl_byte_en    = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cl_done, mem_wr_req, mem_rd_req, busy, grant_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: done=%b wr=%b rd=%b busy=%b gid=%0d, required all 0",
                     cl_done, mem_wr_req, mem_rd_req, busy, grant_id);
        end
        n_checks++;
        if ({cl_q, mem_addr, mem_data, mem_byte_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: q=%h addr=%h data=%h be=%b, required 0", cl_q, mem_addr, mem_data, mem_byte_en);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_gate();
        logic ok;
        set_client(0, 1'b1, 25'h000_0100, 32'hA0A0_0001, 2'b01);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_pulses + rd_pulses != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_gate: pulses=%0d busy=%b, required 0 pulses while init low", wr_pulses + rd_pulses, busy);
        end
        init_complete = 1'b1;
        sb.push_back('{id: 2'd0, q: cur_q});
        wait_done(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL init_done: no cl_done seen, required client %0d", e.id);
        end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
            n_fail++;
            $display("FAIL init_done: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                     cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
        end
        cl_req[0] = 1'b0;
        n_checks++;
        if (wr_pulses != 1 || last_addr !== 25'h000_0100 || last_data !== 32'hA0A0_0001 || last_be !== 2'b01) begin
            n_fail++;
            $display("FAIL init_fields: wr_pulses=%0d addr=%h data=%h be=%b, required 1 000100 a0a00001 01",
                     wr_pulses, last_addr, last_data, last_be);
        end
    endtask

    task automatic test_write_client2();
        int   wr0;
        logic seen;
        logic unstable;
        wr0      = wr_pulses;
        seen     = 1'b0;
        unstable = 1'b0;
        set_client(2, 1'b1, 25'h032_2020, 32'h1234_5678, 2'h3);
        sb.push_back('{id: 2'd2, q: cur_q});
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (busy && (mem_addr !== 25'h032_2020 || mem_data !== 32'h1234_5678 || mem_byte_en !== 2'h3))
                unstable = 1'b1;
            if (cl_done != '0) seen = 1'b1;
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wr2_done: no cl_done seen, required client 2");
        end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
            n_fail++;
            $display("FAIL wr2_done: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                     cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
        end
        cl_req[2] = 1'b0;
        n_checks++;
        if (unstable) begin
            n_fail++;
            $display("FAIL wr2_hold: mem fields changed while busy, required addr 0322020 data 12345678 be 3");
        end
        @(negedge clk);
        n_checks++;
        if (cl_done !== '0 || mem_addr !== '0 || wr_pulses - wr0 != 1) begin
            n_fail++;
            $display("FAIL wr2_after: done=%b addr=%h pulses=%0d, required 0 0 1", cl_done, mem_addr, wr_pulses - wr0);
        end
    endtask

    task automatic test_read_client1();
        logic ok;
        set_client(1, 1'b0, 25'h032_2020, 32'h0, 2'h0);
        cur_q = model_q(25'h032_2020, 32'h1234_5678);
        sb.push_back('{id: 2'd1, q: cur_q});
        wait_done(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rd1_done: no cl_done seen, required client 1");
        end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
            n_fail++;
            $display("FAIL rd1_done: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                     cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
        end
        n_checks++;
        if (cl_q[31:0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rd1_word: q[31:0]=%h, required 12345678", cl_q[31:0]);
        end
        cl_req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic ok;
        apply_reset();
        for (int c = 0; c < N; c++) set_client(c, 1'b0, 25'h000_0200 + 25'(c), 32'h0, 2'h0);
        for (int k = 0; k < 5; k++) begin
            cur_q = model_q(25'h000_0200 + 25'(k % N), 32'h0);
            sb.push_back('{id: 2'(k % N), q: cur_q});
        end
        for (int k = 0; k < 5; k++) begin
            wait_done(ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_done%0d: no cl_done seen, required client %0d", k, e.id);
            end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
                n_fail++;
                $display("FAIL rr_done%0d: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                         k, cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
            end
            if (k == 4) cl_req = '0;
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || cl_done !== '0) begin
                n_fail++;
                $display("FAIL rr_gap%0d: busy=%b done=%b, required idle cycle after done", k, busy, cl_done);
            end
        end
    endtask

    task automatic test_withdraw();
        logic ok;
        int   p0;
        int   extra;
        p0        = wr_pulses + rd_pulses;
        extra     = 0;
        model_lat = 6;
        set_client(0, 1'b1, 25'h000_0300, 32'h55AA_33CC, 2'h2);
        sb.push_back('{id: 2'd0, q: cur_q});
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        set_client(3, 1'b0, 25'h000_0333, 32'h0, 2'h0);
        repeat (2) @(negedge clk);
        cl_req[3] = 1'b0;
        wait_done(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wd_done: no cl_done seen, required client 0");
        end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
            n_fail++;
            $display("FAIL wd_done: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                     cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
        end
        cl_req[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cl_done != '0 || busy) extra++;
        end
        n_checks++;
        if (extra != 0 || wr_pulses + rd_pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL wd_client3: busy/done cycles=%0d pulses=%0d, required 0 and 1", extra, wr_pulses + rd_pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int   r0;
        model_lat = 8;
        set_client(0, 1'b0, 25'h032_2020, 32'h0, 2'h0);
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_inflight: busy=%b mem_ready=%b, required 1 0", busy, mem_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, mem_rd_req, mem_wr_req, cl_done, grant_id} !== '0 || {mem_addr, cl_q} !== '0) begin
            n_fail++;
            $display("FAIL rm_async: busy=%b rd=%b wr=%b done=%b gid=%0d addr=%h q=%h, required all 0",
                     busy, mem_rd_req, mem_wr_req, cl_done, grant_id, mem_addr, cl_q);
        end
        abort_gen++;
        cur_q     = '0;
        model_lat = 3;
        repeat (2) @(negedge clk);
        r0      = rd_pulses;
        reset_n = 1'b1;
        cur_q   = model_q(25'h032_2020, 32'h1234_5678);
        sb.push_back('{id: 2'd0, q: cur_q});
        wait_done(ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rm_done: no cl_done seen, required client 0");
        end else if (cl_done !== (4'b0001 << e.id) || grant_id !== e.id || cl_q !== e.q) begin
            n_fail++;
            $display("FAIL rm_done: done=%b gid=%0d q=%h, required done=%b gid=%0d q=%h",
                     cl_done, grant_id, cl_q, 4'b0001 << e.id, e.id, e.q);
        end
        cl_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rd_pulses - r0 != 1) begin
            n_fail++;
            $display("FAIL rm_reissue: rd pulses=%0d, required 1", rd_pulses - r0);
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_write_client2();
        test_read_client1();
        test_round_robin();
        test_withdraw();
        test_reset_mid();
        n_checks++;
        if (proto_err != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL protocol: errors=%0d leftover=%0d, required 0 0", proto_err, sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one port of the dual-port `sdram` controller (typically port 1: 25-bit word address, 32-bit write data, 2-bit byte enable, 128-bit read burst) among several independent clients. It latches the winning client's request, drives the controller's single-cycle `wr_req`/`rd_req` pulse, tracks the controller's `ready` handshake to completion, and returns a one-cycle done strobe plus read data to the granted client. It sits between client logic and the `sdram` module, gated by `init_complete`.

## Interface
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 25: SDRAM word address width.
- `DATA_WIDTH`, 32: write data width per transaction.
- `BE_WIDTH`, 2: byte-enable width.
- `Q_WIDTH`, 128: read burst width.

- `clk`  in  1  single clock, shared with `sdram`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init_complete`  in  1  from `sdram`; no grant is issued while low.
- `cl_req`  in  NUM_CLIENTS  level request per client.
- `cl_we`  in  NUM_CLIENTS  1 = write, 0 = read.
- `cl_addr`  in  NUM_CLIENTS*ADDR_WIDTH  packed, client i at slice i.
- `cl_data`  in  NUM_CLIENTS*DATA_WIDTH  packed write data.
- `cl_byte_en`  in  NUM_CLIENTS*BE_WIDTH  packed byte enables.
- `cl_done`  out  NUM_CLIENTS  one-cycle completion strobe, one-hot.
- `cl_q`  out  Q_WIDTH  read data, valid while `cl_done` asserted for a read.
- `mem_addr`, `mem_data`, `mem_byte_en`  out  ADDR/DATA/BE_WIDTH  to controller port.
- `mem_wr_req`, `mem_rd_req`  out  1  one-cycle request pulses.
- `mem_ready`  in  1  controller port ready.
- `mem_q`  in  Q_WIDTH  controller read data.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_CLIENTS)  index of current/last granted client.

## Operation
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, DONE.
- IDLE: if `init_complete && mem_ready && |cl_req`, pick winner by round-robin starting at `rr_ptr`; latch its we/addr/data/byte_en and index; go ISSUE.
- ISSUE: assert exactly one of `mem_wr_req`/`mem_rd_req` for one cycle; go WAIT_ACCEPT.
- WAIT_ACCEPT: wait for `mem_ready == 0`; go WAIT_DONE.
- WAIT_DONE: wait for `mem_ready == 1`; on that cycle capture `mem_q` into `cl_q` if read (writes leave `cl_q` unchanged); go DONE.
- DONE: `cl_done[grant_id] = 1`; `rr_ptr <= grant_id + 1` (mod NUM_CLIENTS); go IDLE.
- `mem_addr/data/byte_en` hold latched values from ISSUE through DONE; zero in IDLE.
- Clients hold `cl_req` and fields stable until their `cl_done`; must drop `cl_req` on the cycle after `cl_done` or are re-arbitrated (fairness preserved by pointer advance).
- Request withdrawn before grant: ignored. After grant: transaction completes regardless.
- `init_complete` falling mid-transaction: current transaction completes; no new grant.

## Timing
- Reset (async assert, sync release): state IDLE, `rr_ptr` 0, all outputs 0 including `cl_q`, `grant_id`, `busy`.
- Request visible in IDLE at cycle 0 -> ISSUE pulse at cycle 1 -> `cl_done` one cycle after `mem_ready` returns high.
- Back-to-back: next grant evaluated the cycle after DONE; minimum 1 idle cycle between transactions.
- Reset mid-transaction: all outputs drop immediately; in-flight controller operation abandoned (controller reset separately).
- Single requester repeatedly requesting: granted every transaction, no starvation of others once they request (max wait NUM_CLIENTS-1 transactions).

## Structure
- Package `sdram_arb_pkg`: state enum `arb_state_t`, default width localparams.
- Sub-module `rr_picker`: combinational round-robin priority select (req vector + pointer -> valid + index).
- Top `sdram_port_arbiter`: FSM, latches, pointer, output registers.

## Test plan
- Reset then `init_complete` low with `cl_req=4'b0001` -> no `mem_*_req` until `init_complete` rises; then `mem_wr_req` pulse with client 0 fields.
- Client 2 writes addr 25'h0_32_2020, data 32'h1234_5678, be 2'h3 -> one `mem_wr_req` pulse, `mem_addr/data` stable until `cl_done[2]` single-cycle pulse after `mem_ready` re-rises.
- Client 1 reads addr 25'h0_32_2020 after above write -> `cl_q[31:0]` = 32'h1234_5678 with `cl_done[1]`.
- All four clients request simultaneously, held -> grants in order 0,1,2,3, then 0 again; `grant_id` follows.
- Client 3 drops `cl_req` before grant while client 0 active -> client 3 never granted, no stray pulse.
- Assert `reset_n` low during WAIT_DONE -> all outputs 0 asynchronously; after release, pending client 0 request is re-issued cleanly.
